// File: rtl/mmu_pkg.sv
// -----------------------------------------------------------------------------
// mmu_pkg
// Shared definitions for the matrix-unit datapath blocks.
//   feeder_state_e : state encoding of the ifmap skew feeder (IDLE/STREAM/DRAIN)
//   drain_cnt_width: width of the drain down-counter for a given row count
// -----------------------------------------------------------------------------
package mmu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } feeder_state_e;

    // One extra bit over clog2 so the load value ROWS-1 always fits,
    // including the degenerate ROWS=1 build.
    function automatic int drain_cnt_width(input int rows);
        return $clog2(rows) + 1;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// -----------------------------------------------------------------------------
// skew_delay_line
// Fixed-depth delay line carrying one ifmap element together with its enable.
// A stage only loads new data when the enable arriving with it is set, so the
// output holds the last real element during bubbles.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears data and enables)
//   en_i      : element valid entering the line
//   data_i    : element entering the line
//   en_o      : enable after DEPTH edges
//   data_o    : element after DEPTH edges (holds last value on bubbles)
// -----------------------------------------------------------------------------
module skew_delay_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  en_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DEPTH-1:0]      en_q;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            en_q[0] <= en_i;
            if (en_i) begin
                data_q[0] <= data_i;
            end
            for (int i = 1; i < DEPTH; i++) begin
                en_q[i] <= en_q[i-1];
                if (en_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign en_o   = en_q[DEPTH-1];
    assign data_o = data_q[DEPTH-1];

endmodule

// File: rtl/ifmap_skew_feeder.sv
// -----------------------------------------------------------------------------
// ifmap_skew_feeder
// Accepts one ifmap column per beat and skews it across the PE array rows:
// element r of a beat appears on row r, r+1 edges after acceptance. After the
// last beat of a tile the block drains for ROWS-1 cycles (no new beats) and
// pulses done_o when the last element leaves row ROWS-1.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   in_valid_i   : upstream column valid
//   in_ready_o   : column can be accepted this cycle (combinational)
//   in_data_i    : column, element r at [r*DATA_WIDTH +: DATA_WIDTH]
//   in_last_i    : final column of the tile
//   ifmap_o      : skewed elements, one per row (registered)
//   ifmap_en_o   : per-row element enable (registered)
//   busy_o       : tile in progress (STREAM or DRAIN, combinational)
//   done_o       : one-cycle pulse as the tile's last element leaves the array
// -----------------------------------------------------------------------------
module ifmap_skew_feeder
    import mmu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data_i,
    input  logic                       in_last_i,
    output logic [ROWS*DATA_WIDTH-1:0] ifmap_o,
    output logic [ROWS-1:0]            ifmap_en_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int CNT_W = drain_cnt_width(ROWS);

    feeder_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             beat;

    assign in_ready_o = !rst && (state_q != ST_DRAIN);
    assign beat       = in_valid_i && in_ready_o;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;

    // With a single row the last element leaves on the accepting edge, so
    // the tile completes without a drain phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_STREAM: begin
                if (beat) begin
                    if (!in_last_i) begin
                        state_d = ST_STREAM;
                    end else if (ROWS > 1) begin
                        state_d = ST_DRAIN;
                        cnt_d   = CNT_W'(ROWS - 1);
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        skew_delay_line #(
            .DEPTH      (r + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_line (
            .clk    (clk),
            .rst    (rst),
            .en_i   (beat),
            .data_i (in_data_i[r*DATA_WIDTH +: DATA_WIDTH]),
            .en_o   (ifmap_en_o[r]),
            .data_o (ifmap_o[r*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_ifmap_skew_feeder.sv
module tb_ifmap_skew_feeder;

    localparam int DW = 8;
    localparam int R  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [R*DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [R*DW-1:0] ifmap;
    logic [R-1:0]  ifmap_en;
    logic          busy;
    logic          done;

    logic          rst1 = 1'b1;
    logic          v1 = 1'b0;
    logic [DW-1:0] d1 = '0;
    logic          l1 = 1'b0;
    logic          rdy1;
    logic [DW-1:0] ifmap1;
    logic [0:0]    en1;
    logic          busy1;
    logic          done1;

    ifmap_skew_feeder #(.DATA_WIDTH(DW), .ROWS(R)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_last_i(in_last), .ifmap_o(ifmap),
        .ifmap_en_o(ifmap_en), .busy_o(busy), .done_o(done)
    );

    ifmap_skew_feeder #(.DATA_WIDTH(DW), .ROWS(1)) dut1 (
        .clk(clk), .rst(rst1), .in_valid_i(v1), .in_ready_o(rdy1),
        .in_data_i(d1), .in_last_i(l1), .ifmap_o(ifmap1),
        .ifmap_en_o(en1), .busy_o(busy1), .done_o(done1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: each accepted column is scheduled as "row r shows
    // element r in cycle accept+r"; a last column schedules done and blocks
    // acceptance until its last element has left the array.
    typedef struct packed {
        int            t;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          rowq [R][$];
    int            doneq[$];
    logic [DW-1:0] last_d [R];
    int            blocked_until = 0;
    bit            tile_open = 1'b0;

    initial for (int r = 0; r < R; r++) last_d[r] = '0;

    always @(negedge clk) begin : mon4
        bit            exp_rdy, exp_busy, exp_done, exp_en;
        logic [DW-1:0] exp_d;
        int            e;
        exp_rdy  = !rst && (cyc >= blocked_until);
        exp_busy = tile_open || (cyc < blocked_until);
        chk("in_ready", in_ready, exp_rdy);
        chk("busy", busy, exp_busy);
        for (int r = 0; r < R; r++) begin
            exp_en = 1'b0;
            if (rowq[r].size() > 0 && rowq[r][0].t == cyc) begin
                exp_en    = 1'b1;
                last_d[r] = rowq[r][0].d;
                void'(rowq[r].pop_front());
            end
            exp_d = last_d[r];
            chk($sformatf("row%0d_en", r), ifmap_en[r], exp_en);
            chk($sformatf("row%0d_data", r), ifmap[r*DW +: DW], exp_d);
        end
        exp_done = (doneq.size() > 0 && doneq[0] == cyc);
        if (exp_done) void'(doneq.pop_front());
        chk("done", done, exp_done);
        if (rst) begin
            for (int r = 0; r < R; r++) begin
                rowq[r].delete();
                last_d[r] = '0;
            end
            doneq.delete();
            tile_open     = 1'b0;
            blocked_until = 0;
        end else if (in_valid && exp_rdy) begin
            e = cyc + 1;
            for (int r = 0; r < R; r++)
                rowq[r].push_back('{t: e + r, d: in_data[r*DW +: DW]});
            if (in_last) begin
                doneq.push_back(e + R - 1);
                tile_open     = 1'b0;
                blocked_until = e + R - 1;
            end else begin
                tile_open = 1'b1;
            end
        end
    end

    typedef struct packed {
        int            t;
        logic [DW-1:0] d;
        logic          l;
    } ent1_t;

    ent1_t         q1[$];
    logic [DW-1:0] last1 = '0;
    bit            open1 = 1'b0;

    always @(negedge clk) begin : mon1
        bit            er, een, edn;
        logic [DW-1:0] ed;
        er  = !rst1;
        een = 1'b0;
        edn = 1'b0;
        chk("r1_in_ready", rdy1, er);
        chk("r1_busy", busy1, open1);
        if (q1.size() > 0 && q1[0].t == cyc) begin
            een   = 1'b1;
            edn   = q1[0].l;
            last1 = q1[0].d;
            void'(q1.pop_front());
        end
        ed = last1;
        chk("r1_en", en1, een);
        chk("r1_data", ifmap1, ed);
        chk("r1_done", done1, edn);
        if (rst1) begin
            q1.delete();
            last1 = '0;
            open1 = 1'b0;
        end else if (v1 && er) begin
            q1.push_back('{t: cyc + 1, d: d1, l: l1});
            open1 = !l1;
        end
    end

    task automatic drive(input logic v, input logic [R*DW-1:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive1(input logic v, input logic [DW-1:0] d, input logic l);
        v1 = v;
        d1 = d;
        l1 = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // single tile of three columns
        drive(1'b1, 32'h14131211, 1'b0);
        drive(1'b1, 32'h24232221, 1'b0);
        drive(1'b1, 32'h34333231, 1'b1);
        idle(R + 2);

        // beat, bubble, beat
        drive(1'b1, 32'hA4A3A2A1, 1'b0);
        drive(1'b0, 32'hFFFFFFFF, 1'b0);
        drive(1'b1, 32'hB4B3B2B1, 1'b1);
        idle(R + 2);

        // upstream keeps offering a column throughout the drain
        drive(1'b1, 32'hC4C3C2C1, 1'b0);
        drive(1'b1, 32'hD4D3D2D1, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'hEEEEEEEE;
        in_last  = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("drain_ready_low_cycles", n, 3);
        idle(2);

        // reset after two columns of a five-column tile
        drive(1'b1, 32'h44434241, 1'b0);
        drive(1'b1, 32'h54535251, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h66666666;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        for (int i = 0; i < 5; i++)
            drive(1'b1, $urandom, i == 4);
        idle(R + 2);

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                rst      = 1'b1;
                in_valid = 1'($urandom_range(1));
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                drive($urandom_range(3) != 0, $urandom, $urandom_range(4) == 0);
            end
        end
        idle(R + 4);

        // single-row build
        rst1 = 1'b0;
        drive1(1'b0, 8'h00, 1'b0);
        drive1(1'b1, 8'hAB, 1'b1);
        drive1(1'b0, 8'h00, 1'b0);
        drive1(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(19) == 0) begin
                rst1 = 1'b1;
                v1   = 1'($urandom_range(1));
                @(posedge clk);
                #1;
                rst1 = 1'b0;
            end else begin
                drive1($urandom_range(2) != 0, 8'($urandom), $urandom_range(2) == 0);
            end
        end
        drive1(1'b0, 8'h00, 1'b0);
        drive1(1'b0, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifmap_skew_feeder.md
IFMAP_SKEW_FEEDER -- requirements
Module: ifmap_skew_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the ifmap element width; it matches the PE array element width.
REQ-002 SHALL have parameter ROWS, default 4, the number of PE array rows fed (legal range 1..64).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid_i, input, 1 bit: the upstream vector is valid.
REQ-006 SHALL have port in_ready_o, output, 1 bit: the block can accept a vector this cycle.
REQ-007 SHALL have port in_data_i, input, ROWS*DATA_WIDTH bits: one ifmap column; element r occupies bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port in_last_i, input, 1 bit: marks the final vector of a tile.
REQ-009 SHALL have port ifmap_o, output, ROWS*DATA_WIDTH bits: skewed elements, one per array row.
REQ-010 SHALL have port ifmap_en_o, output, ROWS bits: per-row ifmap register enable, aligned with ifmap_o.
REQ-011 SHALL have port busy_o, output, 1 bit: high in the STREAM or DRAIN state.
REQ-012 SHALL have port done_o, output, 1 bit: a one-cycle pulse when the last element of a tile leaves row ROWS-1.

Function
REQ-013 SHALL accept a vector on a clock edge where in_valid_i and in_ready_o are both high (a "beat").
REQ-014 SHALL present element r of a beat accepted at edge t on ifmap_o row r, with ifmap_en_o[r]=1, during the cycle following edge t+r; the latency is r+1 edges.
REQ-015 SHALL treat a cycle without a beat as a bubble: the matching ifmap_en_o[r] is 0 in its skewed slot, and the data in that slot is don't-care but deterministic (hold the last value).
REQ-016 SHALL implement the FSM states IDLE, STREAM and DRAIN.
REQ-017 SHALL move from IDLE to STREAM on a beat with in_last_i=0, and from IDLE to DRAIN on a beat with in_last_i=1 when ROWS>1.
REQ-018 SHALL move from STREAM to DRAIN on a beat with in_last_i=1; it remains in STREAM otherwise, including on bubbles.
REQ-019 SHALL stay in DRAIN for exactly ROWS-1 cycles, counted by a down-counter of width clog2(ROWS)+1, and then return to IDLE.
REQ-020 SHALL, when ROWS=1, return to IDLE on the edge that accepts the last beat; DRAIN is never entered.
REQ-021 SHALL drive in_ready_o = !rst && (state != DRAIN); a new tile is not accepted until the previous tile has fully drained.
REQ-022 SHALL assert done_o in the cycle in which row ROWS-1 presents the last beat's element, that is, after edge t_last+ROWS-1.
REQ-023 SHALL not let done_o and the next tile's first output on row 0 overlap in a way that loses data; back-to-back tiles are legal, and a new beat may be accepted in the cycle done_o is high.
REQ-024 SHALL leave ifmap_en_o entirely 0 in IDLE once any prior tile has drained.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, clear all skew-stage data to 0 and all enables to 0, clear the drain counter, and enter IDLE.
REQ-026 SHALL, for reset asserted mid-tile (in STREAM or DRAIN), discard all in-flight elements; done_o is not asserted for the aborted tile.
REQ-027 SHALL, in the cycle after reset, output ifmap_o=0, ifmap_en_o=0, busy_o=0, done_o=0 and in_ready_o=1.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE=0, STREAM=1, DRAIN=2) in the shared package mmu_pkg.
REQ-029 SHALL build each row from a sub-module skew_delay_line (parameters DEPTH and DATA_WIDTH) that carries data and the enable together; the sub-module for row r has DEPTH=r+1.
REQ-030 SHALL keep all outputs registered except in_ready_o and busy_o.

Verification
REQ-031 SHALL cover the single tile case: ROWS=4, 3 consecutive beats carrying 0x11..0x14, 0x21..0x24 and 0x31..0x34, the last beat with in_last_i=1; the required response is row r shows 0x1(r+1), 0x2(r+1), 0x3(r+1) starting r+1 cycles after the first beat, and done_o pulses 6 cycles after the first accept edge.
REQ-032 SHALL cover bubbles: the sequence beat, idle, beat; ifmap_en_o[r] must read 1,0,1 in the skewed slots of every row.
REQ-033 SHALL cover backpressure: driving in_valid_i=1 throughout DRAIN must leave in_ready_o=0 for exactly 3 cycles and take no beat.
REQ-034 SHALL cover reset mid-tile: rst asserted after 2 beats of a 5-beat tile must clear all enables next cycle, raise no done_o, and let a fresh tile run correctly afterward.
REQ-035 SHALL cover the ROWS=1 build: a single beat 0xAB with last=1 must give ifmap_o=0xAB, en=1 and done_o=1 in the same cycle, one edge after acceptance.
